// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI-to-register bridge: FSM states,
// command byte layout, frame lengths and the read-data load latency.
package spi_reg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2,
        ST_HOLD = 2'd3
    } spi_state_e;

    localparam int CMD_RW_BIT    = 7;
    localparam int CMD_ADDR_MSB  = 5;
    localparam int CMD_BITS      = 8;
    localparam int DATA_BITS     = 32;
    localparam int READ_LOAD_LAT = 3;
    localparam int ADDR_W        = CMD_ADDR_MSB + 1;
    localparam int LOAD_CNT_W    = 2;

    // Burst address step; the 6-bit width gives the 0x3F -> 0x00 wrap.
    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        return a + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/spi_sync.sv
// Synchronizes SCLK, CS_n and MOSI into clk and detects SCLK/CS edges.
// Edges are suppressed until the chains are refilled after reset.
module spi_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sclk_i,
    input  logic cs_n_i,
    input  logic mosi_i,
    output logic mosi_o,
    output logic cs_n_o,
    output logic sclk_rise_o,
    output logic sclk_fall_o,
    output logic cs_fall_o,
    output logic cs_rise_o
);

    localparam logic [2:0] WARM_DONE = 3'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sclk_prev_q;
    logic                   cs_prev_q;
    logic [2:0]             warm_q;
    logic                   edges_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            warm_q      <= 3'd0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
            cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
            if (warm_q != WARM_DONE) begin
                warm_q <= warm_q + 3'd1;
            end
        end
    end

    // A CS held low across reset must not look like a fresh falling edge.
    assign edges_en    = (warm_q == WARM_DONE);

    assign mosi_o      = mosi_sync_q[SYNC_STAGES-1];
    assign cs_n_o      = cs_sync_q[SYNC_STAGES-1];
    assign sclk_rise_o = edges_en &  sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
    assign sclk_fall_o = edges_en & ~sclk_sync_q[SYNC_STAGES-1] &  sclk_prev_q;
    assign cs_fall_o   = edges_en & ~cs_sync_q[SYNC_STAGES-1]   &  cs_prev_q;
    assign cs_rise_o   = edges_en &  cs_sync_q[SYNC_STAGES-1]   & ~cs_prev_q;

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave to 64x32-bit register bridge: command byte then one 32-bit word.
// Define SPI_REG_BRIDGE_BURST_EN to continue with address-incremented words while CS stays low.
module spi_reg_bridge
    import spi_reg_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_sclk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic [ADDR_W-1:0] reg_address,
    output logic [31:0]       reg_wr_data,
    output logic              reg_wr_valid,
    input  logic [31:0]       reg_rd_data,
    output logic              reg_read,
    output spi_state_e        dbg_state_o
);

    logic mosi_s, cs_n_s, sclk_rise, sclk_fall, cs_fall, cs_rise;

    spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk         (clk),
        .rst         (rst),
        .sclk_i      (spi_sclk),
        .cs_n_i      (spi_cs_n),
        .mosi_i      (spi_mosi),
        .mosi_o      (mosi_s),
        .cs_n_o      (cs_n_s),
        .sclk_rise_o (sclk_rise),
        .sclk_fall_o (sclk_fall),
        .cs_fall_o   (cs_fall),
        .cs_rise_o   (cs_rise)
    );

    spi_state_e              state_q, state_d;
    logic [5:0]              bit_cnt_q, bit_cnt_d;
    logic [CMD_BITS-1:0]     cmd_sr_q, cmd_sr_d;
    logic [DATA_BITS-1:0]    data_sr_q, data_sr_d;
    logic [DATA_BITS-1:0]    miso_sr_q, miso_sr_d;
    logic                    is_read_q, is_read_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [31:0]             wr_data_q, wr_data_d;
    logic                    wr_valid_q, wr_valid_d;
    logic                    rd_strobe_q, rd_strobe_d;
    logic [LOAD_CNT_W-1:0]   load_cnt_q, load_cnt_d;
    logic                    miso_q, miso_d;

    logic [CMD_BITS-1:0]     cmd_byte;
    logic [DATA_BITS-1:0]    word_in;

    assign cmd_byte = {cmd_sr_q[CMD_BITS-2:0], mosi_s};
    assign word_in  = {data_sr_q[DATA_BITS-2:0], mosi_s};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            cmd_sr_q    <= '0;
            data_sr_q   <= '0;
            miso_sr_q   <= '0;
            is_read_q   <= 1'b0;
            addr_q      <= '0;
            wr_data_q   <= '0;
            wr_valid_q  <= 1'b0;
            rd_strobe_q <= 1'b0;
            load_cnt_q  <= '0;
            miso_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            cmd_sr_q    <= cmd_sr_d;
            data_sr_q   <= data_sr_d;
            miso_sr_q   <= miso_sr_d;
            is_read_q   <= is_read_d;
            addr_q      <= addr_d;
            wr_data_q   <= wr_data_d;
            wr_valid_q  <= wr_valid_d;
            rd_strobe_q <= rd_strobe_d;
            load_cnt_q  <= load_cnt_d;
            miso_q      <= miso_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        cmd_sr_d    = cmd_sr_q;
        data_sr_d   = data_sr_q;
        miso_sr_d   = miso_sr_q;
        is_read_d   = is_read_q;
        addr_d      = addr_q;
        wr_data_d   = wr_data_q;
        wr_valid_d  = 1'b0;
        rd_strobe_d = 1'b0;
        load_cnt_d  = (load_cnt_q != '0) ? load_cnt_q - LOAD_CNT_W'(1) : '0;
        miso_d      = miso_q;

        // Read data is captured a fixed number of clocks after the address moves.
        if (load_cnt_q == LOAD_CNT_W'(1)) begin
            miso_sr_d = reg_rd_data;
        end

        case (state_q)
            ST_IDLE: begin
                miso_d = 1'b0;
                if (cs_fall) begin
                    state_d   = ST_CMD;
                    bit_cnt_d = '0;
                    cmd_sr_d  = '0;
                    data_sr_d = '0;
                end
            end
            ST_CMD: begin
                if (sclk_rise) begin
                    cmd_sr_d = cmd_byte;
                    if (bit_cnt_q == 6'(CMD_BITS - 1)) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                        addr_d    = cmd_byte[CMD_ADDR_MSB:0];
                        is_read_d = cmd_byte[CMD_RW_BIT];
                        if (cmd_byte[CMD_RW_BIT]) begin
                            load_cnt_d = LOAD_CNT_W'(READ_LOAD_LAT);
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 6'd1;
                    end
                end
                if (sclk_fall) begin
                    miso_d = 1'b0;
                end
            end
            ST_DATA: begin
                if (sclk_rise) begin
                    data_sr_d = word_in;
                    if (bit_cnt_q == 6'(DATA_BITS - 1)) begin
                        if (is_read_q) begin
                            rd_strobe_d = 1'b1;
                        end else begin
                            wr_data_d  = word_in;
                            wr_valid_d = 1'b1;
                        end
`ifdef SPI_REG_BRIDGE_BURST_EN
                        bit_cnt_d = '0;
                        addr_d    = addr_inc(addr_q);
                        if (is_read_q) begin
                            load_cnt_d = LOAD_CNT_W'(READ_LOAD_LAT);
                        end
`else
                        state_d = ST_HOLD;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 6'd1;
                    end
                end
                if (sclk_fall) begin
                    if (is_read_q) begin
                        miso_d    = miso_sr_q[DATA_BITS-1];
                        miso_sr_d = {miso_sr_q[DATA_BITS-2:0], 1'b0};
                    end else begin
                        miso_d = 1'b0;
                    end
                end
            end
            ST_HOLD: begin
                if (sclk_fall) begin
                    miso_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Deselect overrides everything: partial frames never strobe.
        if (cs_n_s || cs_rise) begin
            state_d     = ST_IDLE;
            miso_d      = 1'b0;
            load_cnt_d  = '0;
            wr_valid_d  = 1'b0;
            rd_strobe_d = 1'b0;
            wr_data_d   = wr_data_q;
        end
    end

    assign spi_miso     = miso_q;
    assign reg_address  = addr_q;
    assign reg_wr_data  = wr_data_q;
    assign reg_wr_valid = wr_valid_q;
    assign reg_read     = rd_strobe_q;
    assign dbg_state_o  = state_q;

endmodule

// File: doc/spi_reg_bridge.md
SPI_REG_BRIDGE -- requirements
Module: spi_reg_bridge

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the synchronizer depth applied to spi_sclk, spi_cs_n and spi_mosi (legal values 2..3).
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all logic is in this domain.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port spi_sclk, input, 1 bit: SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-005 SHALL have port spi_cs_n, input, 1 bit: chip select, active low.
REQ-006 SHALL have port spi_mosi, input, 1 bit: host data in, MSB first.
REQ-007 SHALL have port spi_miso, output, 1 bit: data to host, MSB first; 0 while spi_cs_n is high.
REQ-008 SHALL have port reg_address, output, 6 bits: register address.
REQ-009 SHALL have port reg_wr_data, output, 32 bits: write word.
REQ-010 SHALL have port reg_wr_valid, output, 1 bit: one-cycle write strobe.
REQ-011 SHALL have port reg_rd_data, input, 32 bits: registered read data, valid 1 clk after reg_address is stable.
REQ-012 SHALL have port reg_read, output, 1 bit: one-cycle read-completed strobe (clears read-sensitive status).

Function
REQ-013 SHALL use frame = 1 command byte (bit7 = 1 read / 0 write, bit6 ignored, bits5:0 address) followed by 32 data bits.
REQ-014 SHALL sample MOSI on the synchronized SCLK rising edge and update MISO on the synchronized falling edge; SCLK period SHALL be at least 16 clk periods.
REQ-015 SHALL use FSM states IDLE, CMD, DATA, HOLD; CS falling edge -> CMD; 8th rising edge -> DATA; 32nd data rising edge -> HOLD (or DATA again per REQ-024); CS high in any state -> IDLE.
REQ-016 SHALL drive reg_address on the cycle after the 8th command rising edge and hold it stable until the next command or burst increment.
REQ-017 SHALL load the 32-bit MISO shift register from reg_rd_data exactly 3 clk after reg_address update for reads; bit31 SHALL appear on the first data-phase falling edge.
REQ-018 SHALL pulse reg_read for exactly 1 clk, 1 clk after the 32nd data rising edge of a read.
REQ-019 SHALL present reg_wr_data and pulse reg_wr_valid for exactly 1 clk, 1 clk after the 32nd data rising edge of a write; reg_wr_data SHALL be held until the next write.
REQ-020 SHALL abort on CS deassertion before the 32nd data bit: no reg_wr_valid, no reg_read, partial data discarded.
REQ-021 SHALL drive MISO 0 during the command byte and during write data.
REQ-022 SHALL use a 6-bit bit counter that resets on every CS falling edge; extra SCLK edges in HOLD SHALL be ignored.

Reset
REQ-023 SHALL, while rst is high, force state IDLE, spi_miso 0, reg_address 0, reg_wr_data 0, reg_wr_valid 0, reg_read 0, all shift registers, counters and synchronizers 0 (cs_n synchronizer to 1); reset mid-frame SHALL emit no strobe, and the frame SHALL be ignored until the next CS falling edge.

Configuration
REQ-024 SHALL, with SPI_REG_BRIDGE_BURST_EN defined, after each completed word with CS still low, increment reg_address by 1 (0x3F wraps to 0x00) and remain in DATA for another word of the same direction, with REQ-017..019 timing per word; without it, SHALL enter HOLD after one word, and MISO SHALL be 0 until CS high.

Structure
REQ-025 SHALL place the state enum, command bit positions (CMD_RW_BIT=7, CMD_ADDR_MSB=5), frame lengths (8, 32) and the read-load latency (3) in shared package spi_reg_pkg.
REQ-026 SHALL instantiate one sub-module spi_sync (SYNC_STAGES synchronizer plus rising/falling edge detection for SCLK and CS).

Verification
REQ-027 Write 0x10, data 0x80FF0000 -> single reg_wr_valid, reg_address=0x10, reg_wr_data=0x80FF0000.
REQ-028 Read 0x00 with reg_rd_data=0x41010203 -> MISO shifts 0x41010203 MSB first, one reg_read pulse after bit 32.
REQ-029 Write 0x02, CS released after 20 data bits -> no reg_wr_valid, FSM IDLE, next frame correct.
REQ-030 rst pulsed during a read's data phase -> outputs 0, no reg_read, following write 0x11=0x12345678 correct.
REQ-031 SPI_REG_BRIDGE_BURST_EN defined: read from 0x3F, 2 words -> reg_address 0x3F then 0x00, two reg_read pulses; undefined: same stimulus -> one reg_read, second word MISO all 0.
